// File: rtl/detector_kn_param.sv
// K-of-N run detector: K_ONES marks before K_ZEROS non-marks asserts det.
// Sampling is gated by en; mark polarity is chosen by invert; DET entries are counted.
module detector_kn_param #(
    parameter int unsigned K_ONES  = 5,
    parameter int unsigned K_ZEROS = 5,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dataIn,
    input  logic             en,
    input  logic             invert,
    input  logic             clr_cnt,
    output logic             det,
    output logic             det_pulse,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int unsigned K_MAX = (K_ONES > K_ZEROS) ? K_ONES : K_ZEROS;
    localparam int unsigned CW    = $clog2(K_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DET   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    ones, ones_n;
    logic [CW-1:0]    zeros, zeros_n;
    logic             det_n, det_pulse_n;
    logic [CNT_W-1:0] det_cnt_n;
    logic             mark;

    assign mark = dataIn ^ invert;

    // Next-state, counter and output logic
    always_comb begin
        state_n     = state;
        ones_n      = ones;
        zeros_n     = zeros;
        det_pulse_n = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (mark) begin
                        ones_n  = CW'(1);
                        zeros_n = '0;
                        if (K_ONES == 1) begin
                            state_n     = DET;
                            det_pulse_n = 1'b1;
                        end else begin
                            state_n = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (mark) begin
                        ones_n = ones + CW'(1);
                        if (ones + CW'(1) == CW'(K_ONES)) begin
                            state_n     = DET;
                            det_pulse_n = 1'b1;
                        end
                    end else begin
                        zeros_n = zeros + CW'(1);
                        if (zeros + CW'(1) == CW'(K_ZEROS)) begin
                            state_n = IDLE;
                            ones_n  = '0;
                            zeros_n = '0;
                        end
                    end
                end
                DET: begin
                    if (!mark) begin
                        state_n = IDLE;
                        ones_n  = '0;
                        zeros_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    ones_n  = '0;
                    zeros_n = '0;
                end
            endcase
        end

        det_n = (state_n == DET);

        // Clear beats a simultaneous increment; count saturates at all-ones
        det_cnt_n = det_cnt;
        if (clr_cnt) begin
            det_cnt_n = '0;
        end else if (det_pulse_n && (det_cnt != {CNT_W{1'b1}})) begin
            det_cnt_n = det_cnt + CNT_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ones      <= '0;
            zeros     <= '0;
            det       <= 1'b0;
            det_pulse <= 1'b0;
            det_cnt   <= '0;
        end else begin
            state     <= state_n;
            ones      <= ones_n;
            zeros     <= zeros_n;
            det       <= det_n;
            det_pulse <= det_pulse_n;
            det_cnt   <= det_cnt_n;
        end
    end

endmodule
